// File: rtl/corr_pkt_pkg.sv
// Shared definitions for the correlator packet stream.
// Both the packetiser and the reader use this byte layout.
package corr_pkt_pkg;

    localparam int PKT_NBYTES = 5;

    localparam logic [2:0] PKT_IDX_WINNUM  = 3'd0;
    localparam logic [2:0] PKT_IDX_X       = 3'd1;
    localparam logic [2:0] PKT_IDX_Y       = 3'd2;
    localparam logic [2:0] PKT_IDX_ISECT   = 3'd3;
    localparam logic [2:0] PKT_IDX_SYMDIFF = 3'd4;

    typedef struct packed {
        logic [7:0] symdiff;
        logic [7:0] isect;
        logic [7:0] y;
        logic [7:0] x;
        logic [7:0] winNum;
    } corr_pkt_t;

endpackage

// File: rtl/corr_pkt_reader.sv
// Consumer end of the correlator packet stream: reassembles 5-byte packets from a
// first-word-fall-through FIFO, presents them with valid/ready and tracks lost windows.
module corr_pkt_reader
    import corr_pkt_pkg::*;
#(
    parameter int MISS_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cg,
    input  logic [7:0]        i_data,
    input  logic              i_empty,
    output logic              o_pop,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_winNum,
    output logic [7:0]        o_countX,
    output logic [7:0]        o_countY,
    output logic [7:0]        o_countIsect,
    output logic [7:0]        o_countSymdiff,
    output logic              o_seqErr,
    output logic [MISS_W-1:0] o_missCount
);

    localparam int SUM_W = ((MISS_W > 8) ? MISS_W : 8) + 1;

    function automatic logic [MISS_W-1:0] sat_add(input logic [MISS_W-1:0] acc,
                                                  input logic [7:0] gap);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] top;
        sum = SUM_W'(acc) + SUM_W'(gap);
        top = SUM_W'({MISS_W{1'b1}});
        return (sum > top) ? {MISS_W{1'b1}} : sum[MISS_W-1:0];
    endfunction

    logic [2:0]        byte_idx;
    logic [3:0][7:0]   shadow;
    corr_pkt_t         pkt_q;
    logic              valid;
    logic              seq_err;
    logic [MISS_W-1:0] miss_count;
    logic [7:0]        last_win;
    logic              have_ref;

    logic              pop;
    logic              load;
    corr_pkt_t         new_pkt;
    logic [7:0]        gap;
    logic              mismatch;

    // The final byte may only be taken when the output register can accept a new packet.
    assign pop      = i_cg && !i_empty && !i_flush && !i_rst &&
                      (byte_idx != PKT_IDX_SYMDIFF || !valid || i_ready);
    assign load     = pop && (byte_idx == PKT_IDX_SYMDIFF);
    assign new_pkt  = corr_pkt_t'({i_data, shadow[3], shadow[2], shadow[1], shadow[0]});
    // Modulo-256 distance from the expected window; a duplicate wraps to 255.
    assign gap      = new_pkt.winNum - (last_win + 8'd1);
    assign mismatch = have_ref && (gap != 8'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_idx   <= '0;
            shadow     <= '0;
            pkt_q      <= '0;
            valid      <= 1'b0;
            seq_err    <= 1'b0;
            miss_count <= '0;
            last_win   <= '0;
            have_ref   <= 1'b0;
        end else if (i_cg) begin
            if (i_flush) begin
                byte_idx <= '0;
                valid    <= 1'b0;
                have_ref <= 1'b0;
                seq_err  <= 1'b0;
            end else begin
                seq_err <= 1'b0;
                if (valid && i_ready)
                    valid <= 1'b0;
                if (pop) begin
                    if (load) begin
                        pkt_q    <= new_pkt;
                        valid    <= 1'b1;
                        byte_idx <= '0;
                        last_win <= new_pkt.winNum;
                        have_ref <= 1'b1;
                        if (mismatch) begin
                            seq_err    <= 1'b1;
                            miss_count <= sat_add(miss_count, gap);
                        end
                    end else begin
                        shadow[byte_idx[1:0]] <= i_data;
                        byte_idx              <= byte_idx + 3'd1;
                    end
                end
            end
        end
    end

    assign o_pop          = pop;
    assign o_valid        = valid;
    assign o_winNum       = pkt_q.winNum;
    assign o_countX       = pkt_q.x;
    assign o_countY       = pkt_q.y;
    assign o_countIsect   = pkt_q.isect;
    assign o_countSymdiff = pkt_q.symdiff;
    assign o_seqErr       = seq_err;
    assign o_missCount    = miss_count;

endmodule

// File: tb/tb_corr_pkt_reader.sv
// Bench for corr_pkt_reader: a byte-queue FIFO feeds two instances (MISS_W=16 and 4)
// whose outputs are compared every cycle against a packet-level reference model.
module tb_corr_pkt_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cg, flush, ready, empty;
    logic [7:0]  data;

    logic        pop_a, valid_a, seq_a;
    logic [7:0]  win_a, x_a, y_a, is_a, sd_a;
    logic [15:0] miss_a;

    logic        pop_b, valid_b, seq_b;
    logic [7:0]  win_b, x_b, y_b, is_b, sd_b;
    logic [3:0]  miss_b;

    corr_pkt_reader #(.MISS_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_data(data), .i_empty(empty),
        .o_pop(pop_a), .i_flush(flush), .o_valid(valid_a), .i_ready(ready),
        .o_winNum(win_a), .o_countX(x_a), .o_countY(y_a), .o_countIsect(is_a),
        .o_countSymdiff(sd_a), .o_seqErr(seq_a), .o_missCount(miss_a)
    );

    corr_pkt_reader #(.MISS_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_data(data), .i_empty(empty),
        .o_pop(pop_b), .i_flush(flush), .o_valid(valid_b), .i_ready(ready),
        .o_winNum(win_b), .o_countX(x_b), .o_countY(y_b), .o_countIsect(is_b),
        .o_countSymdiff(sd_b), .o_seqErr(seq_b), .o_missCount(miss_b)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo[$];
    bit         hide = 1'b0;

    // Reference model state, kept at packet level.
    logic [7:0] part[$];
    logic [7:0] mpkt[5];
    bit         mvalid, mhave, mseq;
    int         mlast, mmiss16, mmiss4;

    int         npops, npulses;
    logic       dut_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic [7:0] w, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] is, input logic [7:0] sd);
        fifo.push_back(w);
        fifo.push_back(x);
        fifo.push_back(y);
        fifo.push_back(is);
        fifo.push_back(sd);
    endtask

    task automatic model_update(input bit mp);
        int exp_win, g;
        if (rst) begin
            part.delete();
            for (int k = 0; k < 5; k++) mpkt[k] = 8'h00;
            mvalid = 0; mhave = 0; mseq = 0; mlast = 0; mmiss16 = 0; mmiss4 = 0;
        end else if (cg) begin
            if (flush) begin
                part.delete();
                mvalid = 0; mhave = 0; mseq = 0;
            end else begin
                mseq = 0;
                if (mvalid && ready) mvalid = 0;
                if (mp) begin
                    part.push_back(data);
                    if (part.size() == 5) begin
                        for (int k = 0; k < 5; k++) mpkt[k] = part[k];
                        exp_win = (mlast + 1) % 256;
                        if (mhave && int'(part[0]) != exp_win) begin
                            g = (int'(part[0]) - exp_win + 256) % 256;
                            mseq = 1;
                            mmiss16 = (mmiss16 + g > 65535) ? 65535 : mmiss16 + g;
                            mmiss4  = (mmiss4 + g > 15) ? 15 : mmiss4 + g;
                        end
                        mlast  = int'(part[0]);
                        mhave  = 1;
                        mvalid = 1;
                        part.delete();
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", valid_a, mvalid);
        chk("seqErr", seq_a, mseq);
        chk("winNum", win_a, mpkt[0]);
        chk("countX", x_a, mpkt[1]);
        chk("countY", y_a, mpkt[2]);
        chk("countIsect", is_a, mpkt[3]);
        chk("countSymdiff", sd_a, mpkt[4]);
        chk("missCount16", miss_a, mmiss16);
        chk("valid_w4", valid_b, mvalid);
        chk("seqErr_w4", seq_b, mseq);
        chk("winNum_w4", win_b, mpkt[0]);
        chk("missCount4", miss_b, mmiss4);
    endtask

    // One clock: drive FIFO head, check the pop decision, advance model and DUT, check state.
    task automatic step();
        bit mp;
        data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
        empty = (fifo.size() == 0) || hide;
        #1;
        mp = cg && !empty && !flush && !rst && (part.size() != 4 || !mvalid || ready);
        chk("pop", pop_a, mp);
        chk("pop_w4", pop_b, mp);
        dut_pop = pop_a;
        model_update(mp);
        @(posedge clk);
        if (mp) begin
            void'(fifo.pop_front());
            npops++;
        end
        #1;
        check_outputs();
        if (seq_a === 1'b1) npulses++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo.delete();
        step();
        rst = 1'b0;
        npops = 0;
        npulses = 0;
    endtask

    initial begin
        logic [7:0] nextwin, w;

        rst = 1'b1; cg = 1'b1; flush = 1'b0; ready = 1'b1; empty = 1'b1; data = 8'h00;
        npops = 0; npulses = 0; dut_pop = 1'b0;
        @(posedge clk); #1;
        step();
        step();
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_winNum", win_a, 8'h00);
        chk("rst_seqErr", seq_a, 1'b0);
        chk("rst_miss", miss_a, 16'h0);
        rst = 1'b0;

        // Single packet, ready high.
        npops = 0;
        push_pkt(8'h00, 8'h10, 8'h20, 8'h30, 8'h40);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_pop_run", dut_pop, 1'b1);
        end
        chk("t1_npops", npops, 5);
        chk("t1_valid", valid_a, 1'b1);
        chk("t1_win", win_a, 8'h00);
        chk("t1_x", x_a, 8'h10);
        chk("t1_y", y_a, 8'h20);
        chk("t1_isect", is_a, 8'h30);
        chk("t1_symdiff", sd_a, 8'h40);
        chk("t1_seqErr", seq_a, 1'b0);
        step();
        chk("t1_accepted", valid_a, 1'b0);

        // Gap of two windows.
        do_reset();
        push_pkt(8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
        push_pkt(8'h06, 8'h11, 8'h12, 8'h13, 8'h14);
        push_pkt(8'h09, 8'h21, 8'h22, 8'h23, 8'h24);
        run(18);
        chk("t2_pulses", npulses, 1);
        chk("t2_miss", miss_a, 16'd2);

        // Wrap is clean; a duplicate costs 255.
        do_reset();
        push_pkt(8'hFF, 8'h01, 8'h02, 8'h03, 8'h04);
        push_pkt(8'h00, 8'h05, 8'h06, 8'h07, 8'h08);
        run(12);
        chk("t3_pulses", npulses, 0);
        chk("t3_miss", miss_a, 16'd0);
        push_pkt(8'h00, 8'h09, 8'h0A, 8'h0B, 8'h0C);
        run(7);
        chk("t3_dup_miss", miss_a, 16'd255);
        chk("t3_dup_miss4", miss_b, 4'd15);

        // Backpressure.
        do_reset();
        ready = 1'b0;
        push_pkt(8'h21, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
        push_pkt(8'h22, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
        run(12);
        chk("t4_npops", npops, 9);
        chk("t4_stall_pop", dut_pop, 1'b0);
        chk("t4_hold_valid", valid_a, 1'b1);
        chk("t4_hold_win", win_a, 8'h21);
        chk("t4_hold_x", x_a, 8'hA1);
        ready = 1'b1;
        step();
        chk("t4_release_pop", dut_pop, 1'b1);
        chk("t4_next_valid", valid_a, 1'b1);
        chk("t4_next_win", win_a, 8'h22);
        chk("t4_next_sd", sd_a, 8'hB4);
        run(2);

        // Flush drops the partial packet and the reference window.
        do_reset();
        push_pkt(8'h10, 8'h01, 8'h02, 8'h03, 8'h04);
        run(6);
        fifo.push_back(8'hAA); fifo.push_back(8'hBB); fifo.push_back(8'hCC);
        run(3);
        flush = 1'b1;
        step();
        chk("t5_flush_valid", valid_a, 1'b0);
        flush = 1'b0;
        npulses = 0;
        push_pkt(8'h80, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
        run(6);
        chk("t5_win", win_a, 8'h80);
        chk("t5_x", x_a, 8'hC1);
        chk("t5_pulses", npulses, 0);
        chk("t5_miss", miss_a, 16'd0);

        // Saturation on the narrow counter, then reset mid-packet.
        do_reset();
        push_pkt(8'd0, 8'h01, 8'h02, 8'h03, 8'h04);
        push_pkt(8'd11, 8'h05, 8'h06, 8'h07, 8'h08);
        push_pkt(8'd22, 8'h09, 8'h0A, 8'h0B, 8'h0C);
        run(17);
        chk("t6_miss16", miss_a, 16'd20);
        chk("t6_miss4_sat", miss_b, 4'd15);
        fifo.push_back(8'h5A); fifo.push_back(8'h5B);
        run(2);
        do_reset();
        chk("t6_rst_valid", valid_a, 1'b0);
        chk("t6_rst_win", win_a, 8'h00);
        chk("t6_rst_sd", sd_a, 8'h00);
        chk("t6_rst_seq", seq_a, 1'b0);
        chk("t6_rst_miss16", miss_a, 16'h0);
        chk("t6_rst_miss4", miss_b, 4'h0);

        // Gated clock holds everything.
        push_pkt(8'h40, 8'h41, 8'h42, 8'h43, 8'h44);
        cg = 1'b0;
        run(3);
        chk("cg_npops", npops, 0);
        cg = 1'b1;
        run(6);
        chk("cg_resume_win", win_a, 8'h40);

        // Randomised traffic with gaps, backpressure, gating and flushes.
        do_reset();
        nextwin = 8'h00;
        for (int i = 0; i < 800; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            cg    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 59) == 0);
            hide  = ($urandom_range(0, 4) == 0);
            if (fifo.size() < 6) begin
                w = nextwin;
                if ($urandom_range(0, 3) == 0) w = w + 8'($urandom_range(0, 255));
                push_pkt(w, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                nextwin = w + 8'd1;
            end
            step();
        end
        cg = 1'b1; flush = 1'b0; hide = 1'b0; ready = 1'b1;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
